vga_text_writer: RTL and testbench
==================================

# vga_text_writer

Downstream stage of the encryption datapath. Takes each encrypted character announced by the datapath's display strobe and places it in a character-cell text buffer. The buffer is an external dual-port RAM that the VGA scan-out reads. The block owns the cursor, line wrap, newline, backspace and full-screen clear, and buffers bursts in a small FIFO.

## Interface
Parameters:
- COLS, 40, text columns per row
- ROWS, 30, text rows
- FIFO_DEPTH, 8, character FIFO entries; power of two, at least 2
- ADDR_W, 11, buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS

Ports:
- clk  in  1  system clock (CLOCK_50); the only clock
- reset  in  1  synchronous, active-high reset
- disp_strobe  in  1  display strobe from the datapath; asynchronous to clk (keyboard_clk domain)
- disp_char  in  8  encrypted character; stable from the strobe rising edge for at least 4 clk cycles
- clear  in  1  clk-domain request to blank the screen
- wr_en  out  1  buffer write enable, one cycle per write
- wr_addr  out  ADDR_W  buffer address = cursor_y*COLS + cursor_x
- wr_data  out  8  character to write
- cursor_x  out  clog2(COLS)  current column
- cursor_y  out  clog2(ROWS)  current row
- busy  out  1  high while a clear sweep runs
- overflow  out  1  sticky; a character was dropped because the FIFO was full

## Operation
- Input capture:
  - disp_strobe passes through a 2-flop synchronizer, then a rising-edge detector.
  - On a detected edge, disp_char is pushed into the FIFO.
  - Push while the FIFO is full and no pop occurs in the same cycle: the character is dropped and overflow is set.
  - Push and pop in the same cycle when full: both take effect, no overflow.
  - overflow clears only on reset or on completion of a clear sweep.
- FSM states: IDLE, WRITE, CLEAR.
  - IDLE:
    - A clear request (latched from a clear pulse) has priority: go to CLEAR.
    - Otherwise, if the FIFO is not empty: pop one character, classify it, go to WRITE.
  - WRITE: perform the action for the popped character, update the cursor, return to IDLE.
  - CLEAR: sweep wr_addr from 0 to COLS*ROWS-1 with wr_data=0x20 and wr_en=1 every cycle. After the last address: cursor=(0,0), overflow=0, return to IDLE.
    - clear pulses during CLEAR are ignored.
    - FIFO pushes continue during CLEAR; no pops occur.
- Character actions:
  - 0x20–0x7E: write the character at the cursor, then advance.
  - 0x0A or 0x0D: no write (wr_en=0 in WRITE); x=0, y=y+1.
  - 0x08, x>0: x=x-1 and write 0x20 at the new position.
  - 0x08, x=0 and y>0: move to (COLS-1, y-1) and write 0x20 there.
  - 0x08 at (0,0): no-op.
  - Any other code: write 0x3F ('?') at the cursor, then advance.
- Advance and wrap:
  - Normal advance: x=x+1.
  - At x=COLS-1: x=0, y=y+1.
  - Row increment from y=ROWS-1 wraps to y=0 (no scrolling).

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0x20, cursor=(0,0), busy=0, overflow=0, FIFO empty, state IDLE, clear request cleared. Reset does not trigger a clear sweep.
- Strobe to FIFO push: disp_strobe rises; the push happens on the 3rd clk edge after that, worst case 4.
- Push to write:
  - Push at edge N with the FIFO empty and the FSM in IDLE.
  - Pop at edge N+1.
  - wr_en=1 during the cycle after N+1; the write commits at edge N+2, together with the cursor update.
- Throughput: 1 character per 2 clk cycles. A clear sweep takes exactly COLS*ROWS cycles with busy=1, plus one cycle to enter CLEAR.
- busy rises on the edge that enters CLEAR and falls on the edge that returns to IDLE.
- cursor_x/cursor_y change only at the end of WRITE or CLEAR.
- wr_addr/wr_data are valid only when wr_en=1; otherwise they hold their last value.
- Reset asserted mid-clear or mid-write: aborts on the next edge; no further wr_en; buffer contents are undefined.

## Test plan
- Reset, then strobe 'A','B' (0x41, 0x42) → writes {addr 0, 0x41}, {addr 1, 0x42}; cursor=(2,0); each wr_en is a single-cycle pulse.
- Place the cursor at (39,29), send 0x5A → write at addr 1199, cursor=(0,0). Then send 0x0D → no wr_en, cursor=(0,1).
- Cursor (0,1), send 0x08 → write {addr 39, 0x20}, cursor=(39,0). At (0,0), send 0x08 → no write, cursor unchanged.
- Send 0x07 → write 0x3F at the cursor, then advance.
- Hold the FSM in CLEAR; push 9 characters → first 8 are kept, overflow=1. After the sweep (1200 writes of 0x20, busy high for 1200 cycles) overflow=0, and the 8 queued characters are written from (0,0).
- Assert reset at the 500th sweep cycle → next cycle busy=0, wr_en=0, cursor=(0,0); no further writes until new input arrives.

Source files
------------

// File: rtl/vga_text_writer.sv
// Character-cell text writer: synchronises the datapath display strobe, queues characters
// in a small FIFO and writes them into the VGA text buffer with cursor, wrap and clear handling.
module vga_text_writer #(
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      disp_strobe,
    input  logic [7:0]                disp_char,
    input  logic                      clear,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_data,
    output logic [$clog2(COLS)-1:0]   cursor_x,
    output logic [$clog2(ROWS)-1:0]   cursor_y,
    output logic                      busy,
    output logic                      overflow
);

    localparam int unsigned XW    = $clog2(COLS);
    localparam int unsigned YW    = $clog2(ROWS);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CELLS = COLS * ROWS;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

    state_t state, state_next;

    // Strobe synchroniser and rising-edge detector
    logic strobe_meta, strobe_sync, strobe_prev;
    logic push_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
            strobe_prev <= 1'b0;
        end else begin
            strobe_meta <= disp_strobe;
            strobe_sync <= strobe_meta;
            strobe_prev <= strobe_sync;
        end
    end

    assign push_c = strobe_sync & ~strobe_prev;

    // Character FIFO; pointers carry one extra wrap bit to tell full from empty
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        empty_c, full_c, pop_c, do_push_c, drop_c;
    logic [7:0]  head_c;
    logic        clear_req;

    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_c    = fifo_mem[rd_ptr[PW-1:0]];
    assign pop_c     = (state == S_IDLE) && !clear_req && !empty_c;
    assign do_push_c = push_c && (!full_c || pop_c);
    assign drop_c    = push_c && full_c && !pop_c;

    always_ff @(posedge clk) begin
        if (do_push_c) fifo_mem[wr_ptr[PW-1:0]] <= disp_char;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop_c)     rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Action for the character at the FIFO head, evaluated against the current cursor
    logic [XW-1:0]     adv_x_c, act_x_c, nxt_x_c;
    logic [YW-1:0]     y_inc_c, adv_y_c, act_y_c, nxt_y_c;
    logic              act_we_c;
    logic [7:0]        act_data_c;
    logic [ADDR_W-1:0] act_addr_c;

    always_comb begin
        y_inc_c    = (cursor_y == YW'(ROWS-1)) ? '0 : cursor_y + YW'(1);
        adv_x_c    = (cursor_x == XW'(COLS-1)) ? '0 : cursor_x + XW'(1);
        adv_y_c    = (cursor_x == XW'(COLS-1)) ? y_inc_c : cursor_y;
        act_we_c   = 1'b1;
        act_x_c    = cursor_x;
        act_y_c    = cursor_y;
        act_data_c = head_c;
        nxt_x_c    = adv_x_c;
        nxt_y_c    = adv_y_c;
        if (head_c >= 8'h20 && head_c <= 8'h7E) begin
            act_data_c = head_c;
        end else if (head_c == 8'h0A || head_c == 8'h0D) begin
            act_we_c = 1'b0;
            nxt_x_c  = '0;
            nxt_y_c  = y_inc_c;
        end else if (head_c == 8'h08) begin
            act_data_c = 8'h20;
            if (cursor_x != '0) begin
                act_x_c = cursor_x - XW'(1);
            end else if (cursor_y != '0) begin
                act_x_c = XW'(COLS-1);
                act_y_c = cursor_y - YW'(1);
            end else begin
                act_we_c = 1'b0;
            end
            nxt_x_c = act_x_c;
            nxt_y_c = act_y_c;
        end else begin
            act_data_c = 8'h3F;
        end
        act_addr_c = ADDR_W'(act_y_c) * ADDR_W'(COLS) + ADDR_W'(act_x_c);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    logic sweep_last_c;
    assign sweep_last_c = (wr_addr == ADDR_W'(CELLS-1));

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (clear_req)     state_next = S_CLEAR;
                else if (!empty_c) state_next = S_WRITE;
            end
            S_WRITE: state_next = S_IDLE;
            S_CLEAR: if (sweep_last_c) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    logic              wr_en_d, busy_d, ovf_clr_c;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;
    logic [XW-1:0]     cursor_x_d, pend_x, pend_x_d;
    logic [YW-1:0]     cursor_y_d, pend_y, pend_y_d;

    always_comb begin
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        busy_d     = busy;
        cursor_x_d = cursor_x;
        cursor_y_d = cursor_y;
        pend_x_d   = pend_x;
        pend_y_d   = pend_y;
        ovf_clr_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear_req) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = 8'h20;
                    busy_d    = 1'b1;
                end else if (!empty_c) begin
                    wr_en_d  = act_we_c;
                    pend_x_d = nxt_x_c;
                    pend_y_d = nxt_y_c;
                    if (act_we_c) begin
                        wr_addr_d = act_addr_c;
                        wr_data_d = act_data_c;
                    end
                end
            end
            S_WRITE: begin
                cursor_x_d = pend_x;
                cursor_y_d = pend_y;
            end
            S_CLEAR: begin
                if (sweep_last_c) begin
                    busy_d     = 1'b0;
                    cursor_x_d = '0;
                    cursor_y_d = '0;
                    ovf_clr_c  = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr + ADDR_W'(1);
                    wr_data_d = 8'h20;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h20;
            busy     <= 1'b0;
            cursor_x <= '0;
            cursor_y <= '0;
            pend_x   <= '0;
            pend_y   <= '0;
        end else begin
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            busy     <= busy_d;
            cursor_x <= cursor_x_d;
            cursor_y <= cursor_y_d;
            pend_x   <= pend_x_d;
            pend_y   <= pend_y_d;
        end
    end

    // Clear request latch (ignored while sweeping) and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_req <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (state == S_IDLE && clear_req)  clear_req <= 1'b0;
            else if (clear && state != S_CLEAR) clear_req <= 1'b1;
            if (drop_c)         overflow <= 1'b1;
            else if (ovf_clr_c) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: directed characters push expected buffer writes,
// a negedge monitor pops and compares every wr_en cycle.
module tb_vga_text_writer;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_strobe;
    logic [7:0]  disp_char;
    logic        clear;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;
    logic        overflow;

    vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(8), .ADDR_W(11)) dut (
        .clk(clk), .reset(reset), .disp_strobe(disp_strobe), .disp_char(disp_char),
        .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    logic prev_wr_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected write
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h, expected no write at %0t",
                             wr_addr, wr_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(wr_data), 32'(mon_e.data));
                end
                if (!busy) check("wr_en_pulse_prev", 32'(prev_wr_en), 32'd0);
            end
        end
        prev_wr_en = wr_en;
    end

    task automatic expect_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.addr = 11'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] ch, input bit we, input int a, input logic [7:0] d);
        if (we) expect_wr(a, d);
        @(posedge clk);
        #3;
        disp_char   = ch;
        disp_strobe = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        disp_strobe = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic check_cursor(input string name, input int x, input int y);
        @(negedge clk);
        #1;
        check({name, "_x"}, 32'(cursor_x), 32'(x));
        check({name, "_y"}, 32'(cursor_y), 32'(y));
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    task automatic wait_busy(input string name, input logic level);
        int n = 0;
        while (busy !== level && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(busy), 32'(level));
    endtask

    initial begin
        reset       = 1'b1;
        disp_strobe = 1'b0;
        disp_char   = 8'h00;
        clear       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'h20);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check_cursor("rst_cursor", 0, 0);
        reset = 1'b0;

        send(8'h41, 1, 0, 8'h41);
        send(8'h42, 1, 1, 8'h42);
        check_cursor("ab_cursor", 2, 0);

        send(8'h0D, 0, 0, 8'h00);
        check_cursor("cr_cursor", 0, 1);
        for (int i = 0; i < 28; i++) send(8'h0A, 0, 0, 8'h00);
        check_cursor("lf_cursor", 0, 29);
        for (int x = 0; x < 39; x++) send(8'(8'h30 + x), 1, 1160 + x, 8'(8'h30 + x));
        check_cursor("row29_cursor", 39, 29);
        send(8'h5A, 1, 1199, 8'h5A);
        check_cursor("wrap_cursor", 0, 0);
        send(8'h0D, 0, 0, 8'h00);
        check_cursor("cr2_cursor", 0, 1);

        send(8'h08, 1, 39, 8'h20);
        check_cursor("bs_row_cursor", 39, 0);
        send(8'h07, 1, 39, 8'h3F);
        check_cursor("ctrl_cursor", 0, 1);
        send(8'h7F, 1, 40, 8'h3F);
        check_cursor("del_cursor", 1, 1);
        send(8'h08, 1, 40, 8'h20);
        check_cursor("bs_cursor", 0, 1);

        // Clear sweep with nine characters arriving mid-sweep
        for (int a = 0; a < CELLS; a++) expect_wr(a, 8'h20);
        busy_cnt = 0;
        pulse_clear();
        wait_busy("clr1_busy_rise", 1'b1);
        for (int i = 0; i < 9; i++) send(8'(8'h61 + i), i < 8, i, 8'(8'h61 + i));
        @(negedge clk);
        #1;
        check("clr1_overflow_set", 32'(overflow), 32'd1);
        check("clr1_busy_mid", 32'(busy), 32'd1);
        wait_busy("clr1_busy_fall", 1'b0);
        check("clr1_overflow_clr", 32'(overflow), 32'd0);
        check("clr1_busy_cycles", 32'(busy_cnt), 32'(CELLS));
        repeat (20) @(posedge clk);
        check_cursor("clr1_cursor", 8, 0);
        check("clr1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Plain clear, then backspace at the origin
        for (int a = 0; a < CELLS; a++) expect_wr(a, 8'h20);
        pulse_clear();
        wait_busy("clr2_busy_rise", 1'b1);
        wait_busy("clr2_busy_fall", 1'b0);
        check_cursor("clr2_cursor", 0, 0);
        send(8'h08, 0, 0, 8'h00);
        check_cursor("bs_origin_cursor", 0, 0);

        // Reset on the 500th sweep write
        for (int a = 0; a < 500; a++) expect_wr(a, 8'h20);
        pulse_clear();
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 3000) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("rst_mid_reached", 32'(exp_q.size()), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check("rst_mid_cursor_x", 32'(cursor_x), 32'd0);
        check("rst_mid_cursor_y", 32'(cursor_y), 32'd0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
